rc4_core: RTL and testbench
===========================

// Module: rc4_core
// PURPOSE
//  RC4 keystream generator: loads a key of up to NUMS_OF_BYTES bytes and runs KSA (S-box init + key scheduling).
//  Then runs PRGA to produce NUMS_OF_BYTES keystream bytes on data_out and pulses done.
//  Standalone crypto block. S-box is internal. Swap/index datapath is exported as debug ports.
// PARAMETERS
//  NUMS_OF_BYTES  16  max key length in bytes AND number of keystream bytes produced
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        synchronous reset, ACTIVE-HIGH despite the name (one clock, sync active-high)
//  start       in   1        level; sampled in IDLE to begin
//  key         in   8*N      key byte m at key[m*8+:8], byte 0 = LSBs
//  key_length  in   8        key bytes used, 1..N; 0 or >N treated as N
//  data_out    out  8*N      keystream byte m at data_out[m*8+:8]
//  done        out  1        high while in DONE
//  state       out  3        FSM state encoding (below)
//  KSA / PRGA  out  1 each   high during KSA states / PRGA states
//  i, j, k     out  8 each   RC4 indices; k = key index (KSA) or output byte index (PRGA)
//  ckey        out  8        key byte at index k (from latched key)
//  wen         out  1        S-box write enable (ports 2 and 3 write together)
//  raddr_1/rdata_1  out 8    S-box async read port 1
//  waddr_2/wdata_2  out 8    S-box write port 2
//  addr_3/rdata_3/wdata_3 out 8   S-box port 3: async read, write
//  temp_addr   out  8        latched PRGA output index S[i]+S[j]
// BEHAVIOUR
//  S-box: 256x8 register array, combinational reads. Writes on clk when wen=1.
//   If waddr_2==addr_3, port 3 wins.
//  Arithmetic: all index sums are mod 256 (8-bit wrap).
//  Reset: state=IDLE(0), every output, data_out and counter = 0. S-box contents are don't-care.
//   Reset mid-operation aborts to IDLE on the next edge.
//  States: IDLE=0 INIT=1 KSA_RD=2 KSA_SW=3 PRGA_RD=4 PRGA_SW=5 PRGA_OUT=6 DONE=7.
//  IDLE: if start, latch key/key_length, clear i,j,k,data_out, go INIT.
//  INIT: S[i]=i (wen=1, waddr_2=wdata_2=i), i++. After i=255, go KSA_RD with i=j=k=0.
//  KSA_RD: raddr_1=i. j<=j+rdata_1+ckey. temp<=rdata_1.
//   k<=(k==len-1)?0:k+1. Go KSA_SW.
//  KSA_SW: addr_3=j, wen=1. S[i]<=rdata_3 via port 2; S[j]<=temp via port 3. i++.
//   If i was 255: go PRGA_RD with i=1, j=0, k=0. Else go KSA_RD.
//  PRGA_RD: raddr_1=i. j<=j+rdata_1. temp<=rdata_1. Go PRGA_SW.
//  PRGA_SW: swap S[i] and S[j] as in KSA_SW. temp_addr<=temp+rdata_3. Go PRGA_OUT.
//  PRGA_OUT: raddr_1=temp_addr. data_out[k*8+:8]<=rdata_1. i++.
//   If k==N-1: go DONE. Else k++ and go PRGA_RD.
//  DONE: done=1, data_out held. Go IDLE when start==0.
//   start held high stays in DONE; no auto-restart.
//  start is ignored outside IDLE/DONE. key/key_length changes after latch are ignored.
//  Latency from start sampled to done=1: 1+256+512+3N cycles (817 for N=16).
//  i==j swap leaves S unchanged.
//  Repeated runs use only the latched key; no state leaks between runs (INIT rebuilds S).
// TESTING
//  key="Key" (4B 65 79), len=3, start -> done at cycle 817;
//   data_out bytes 0..9 = EB 9F 77 81 B7 34 CA 72 A7 19.
//  key="Wiki", len=4 -> bytes 0..5 = 60 44 DB 6D 41 B7.
//  key="Secret", len=6 -> bytes 0..7 = 04 D4 6B 05 3C A8 7B 59.
//  Reset asserted mid-KSA -> state=0, done=0, data_out=0 next cycle.
//   New start gives the same result as a fresh run.
//  Hold start high after done -> done stays 1, no restart.
//   Drop start -> IDLE. Re-raise with key "Wiki" -> Wiki vector.
//  key_length=0 with 16-byte key 00..0F -> same data_out as key_length=16.

Source files
------------

// File: rtl/rc4_core.sv
// RC4 keystream generator: S-box init, key scheduling (KSA) and PRGA over a
// 256x8 register S-box, producing NUMS_OF_BYTES keystream bytes per start.
module rc4_core #(
   parameter int NUMS_OF_BYTES = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [8*NUMS_OF_BYTES-1:0] key,
   input  logic [7:0]                 key_length,
   output logic [8*NUMS_OF_BYTES-1:0] data_out,
   output logic                       done,
   output logic [2:0]                 state,
   output logic                       KSA,
   output logic                       PRGA,
   output logic [7:0]                 i,
   output logic [7:0]                 j,
   output logic [7:0]                 k,
   output logic [7:0]                 ckey,
   output logic                       wen,
   output logic [7:0]                 raddr_1,
   output logic [7:0]                 rdata_1,
   output logic [7:0]                 waddr_2,
   output logic [7:0]                 wdata_2,
   output logic [7:0]                 addr_3,
   output logic [7:0]                 rdata_3,
   output logic [7:0]                 wdata_3,
   output logic [7:0]                 temp_addr
);

   localparam logic [7:0] N8 = 8'(NUMS_OF_BYTES);
   localparam int         DW = 8*NUMS_OF_BYTES;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INIT     = 3'd1,
      S_KSA_RD   = 3'd2,
      S_KSA_SW   = 3'd3,
      S_PRGA_RD  = 3'd4,
      S_PRGA_SW  = 3'd5,
      S_PRGA_OUT = 3'd6,
      S_DONE     = 3'd7
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      i_q, i_d, j_q, j_d, k_q, k_d;
   logic [7:0]      temp_q, temp_d, temp_addr_q, temp_addr_d;
   logic [7:0]      len_q, len_d;
   logic [DW-1:0]   key_q, key_d, data_out_q, data_out_d;
   logic [7:0]      sbox [256];

   assign rdata_1 = sbox[raddr_1];
   assign rdata_3 = sbox[addr_3];

   // Key byte at index k; k never exceeds N-1 while it is meaningful.
   always_comb begin
      ckey = 8'd0;
      for (int m = 0; m < NUMS_OF_BYTES; m++) begin
         if (k_q == 8'(m)) ckey = key_q[m*8 +: 8];
      end
   end

   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      k_d         = k_q;
      temp_d      = temp_q;
      temp_addr_d = temp_addr_q;
      len_d       = len_q;
      key_d       = key_q;
      data_out_d  = data_out_q;
      wen         = 1'b0;
      raddr_1     = 8'd0;
      waddr_2     = 8'd0;
      wdata_2     = 8'd0;
      addr_3      = 8'd0;
      wdata_3     = 8'd0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               key_d      = key;
               len_d      = (key_length == 8'd0 || key_length > N8) ? N8 : key_length;
               i_d        = 8'd0;
               j_d        = 8'd0;
               k_d        = 8'd0;
               data_out_d = '0;
               state_d    = S_INIT;
            end
         end
         S_INIT: begin
            // Both write ports target the same cell so port 3 cannot clobber anything.
            wen     = 1'b1;
            waddr_2 = i_q;
            wdata_2 = i_q;
            addr_3  = i_q;
            wdata_3 = i_q;
            i_d     = i_q + 8'd1;
            if (i_q == 8'hFF) begin
               j_d     = 8'd0;
               k_d     = 8'd0;
               state_d = S_KSA_RD;
            end
         end
         S_KSA_RD: begin
            raddr_1 = i_q;
            j_d     = j_q + rdata_1 + ckey;
            temp_d  = rdata_1;
            k_d     = (k_q == len_q - 8'd1) ? 8'd0 : k_q + 8'd1;
            state_d = S_KSA_SW;
         end
         S_KSA_SW: begin
            wen     = 1'b1;
            addr_3  = j_q;
            waddr_2 = i_q;
            wdata_2 = rdata_3;
            wdata_3 = temp_q;
            i_d     = i_q + 8'd1;
            if (i_q == 8'hFF) begin
               i_d     = 8'd1;
               j_d     = 8'd0;
               k_d     = 8'd0;
               state_d = S_PRGA_RD;
            end else begin
               state_d = S_KSA_RD;
            end
         end
         S_PRGA_RD: begin
            raddr_1 = i_q;
            j_d     = j_q + rdata_1;
            temp_d  = rdata_1;
            state_d = S_PRGA_SW;
         end
         S_PRGA_SW: begin
            // rdata_3 is old S[j] (new S[i]); temp is old S[i] (new S[j]).
            wen         = 1'b1;
            addr_3      = j_q;
            waddr_2     = i_q;
            wdata_2     = rdata_3;
            wdata_3     = temp_q;
            temp_addr_d = temp_q + rdata_3;
            state_d     = S_PRGA_OUT;
         end
         S_PRGA_OUT: begin
            raddr_1 = temp_addr_q;
            for (int m = 0; m < NUMS_OF_BYTES; m++) begin
               if (k_q == 8'(m)) data_out_d[m*8 +: 8] = rdata_1;
            end
            i_d = i_q + 8'd1;
            if (k_q == N8 - 8'd1) begin
               state_d = S_DONE;
            end else begin
               k_d     = k_q + 8'd1;
               state_d = S_PRGA_RD;
            end
         end
         S_DONE: begin
            if (!start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= S_IDLE;
         i_q         <= 8'd0;
         j_q         <= 8'd0;
         k_q         <= 8'd0;
         temp_q      <= 8'd0;
         temp_addr_q <= 8'd0;
         len_q       <= 8'd0;
         key_q       <= '0;
         data_out_q  <= '0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         k_q         <= k_d;
         temp_q      <= temp_d;
         temp_addr_q <= temp_addr_d;
         len_q       <= len_d;
         key_q       <= key_d;
         data_out_q  <= data_out_d;
      end
   end

   // Port 3 is written last so it wins when both ports hit the same address.
   always_ff @(posedge clk) begin
      if (wen) begin
         sbox[waddr_2] <= wdata_2;
         sbox[addr_3]  <= wdata_3;
      end
   end

   assign data_out  = data_out_q;
   assign done      = (state_q == S_DONE);
   assign state     = state_q;
   assign KSA       = (state_q == S_KSA_RD) || (state_q == S_KSA_SW);
   assign PRGA      = (state_q == S_PRGA_RD) || (state_q == S_PRGA_SW) || (state_q == S_PRGA_OUT);
   assign i         = i_q;
   assign j         = j_q;
   assign k         = k_q;
   assign temp_addr = temp_addr_q;

endmodule

// File: tb/tb_rc4_core.sv
// Directed bench for rc4_core: known RC4 vectors, a reference keystream model,
// reset/abort, start-hold and key_length boundary sequences.
module tb_rc4_core;

   localparam int N   = 16;
   localparam int LAT = 1 + 256 + 512 + 3*N;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [8*N-1:0] key;
   logic [7:0]     key_length;
   logic [8*N-1:0] data_out;
   logic           done;
   logic [2:0]     state;
   logic           KSA, PRGA, wen;
   logic [7:0]     i, j, k, ckey, raddr_1, rdata_1, waddr_2, wdata_2;
   logic [7:0]     addr_3, rdata_3, wdata_3, temp_addr;

   int n_chk  = 0;
   int n_fail = 0;

   rc4_core #(.NUMS_OF_BYTES(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key(key), .key_length(key_length),
      .data_out(data_out), .done(done), .state(state), .KSA(KSA), .PRGA(PRGA),
      .i(i), .j(j), .k(k), .ckey(ckey), .wen(wen),
      .raddr_1(raddr_1), .rdata_1(rdata_1), .waddr_2(waddr_2), .wdata_2(wdata_2),
      .addr_3(addr_3), .rdata_3(rdata_3), .wdata_3(wdata_3), .temp_addr(temp_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string          name;
      logic [8*N-1:0] key;
      logic [7:0]     len;
      int             nexp;
      logic [79:0]    exp;   // first keystream byte in the most significant used byte
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8*N-1:0] rc4_model(input logic [8*N-1:0] kk, input logic [7:0] ln);
      logic [7:0]     s [256];
      logic [7:0]     t;
      logic [7:0]     a, b;
      logic [8*N-1:0] res;
      int             len;
      len = (ln == 8'd0 || int'(ln) > N) ? N : int'(ln);
      for (int x = 0; x < 256; x++) s[x] = 8'(x);
      b = 8'd0;
      for (int x = 0; x < 256; x++) begin
         b = b + s[x] + kk[(x % len)*8 +: 8];
         t = s[x]; s[x] = s[b]; s[b] = t;
      end
      a = 8'd0;
      b = 8'd0;
      res = '0;
      for (int m = 0; m < N; m++) begin
         a = a + 8'd1;
         b = b + s[a];
         t = s[a]; s[a] = s[b]; s[b] = t;
         res[m*8 +: 8] = s[8'(s[a] + s[b])];
      end
      return res;
   endfunction

   // Raise start, count edges to done, then check timing and keystream.
   task automatic run_vec(input vec_t v, input bit scramble);
      int cyc;
      key        = v.key;
      key_length = v.len;
      start      = 1'b1;
      cyc        = 0;
      while (!done && cyc < 2000) begin
         step();
         cyc++;
         if (scramble && cyc == 5) begin
            key        = ~v.key;
            key_length = 8'd1;
         end
      end
      check({v.name, " latency"}, 128'(cyc), 128'(LAT));
      for (int m = 0; m < v.nexp; m++)
         check({v.name, " vector byte"}, 128'(data_out[m*8 +: 8]),
               128'(v.exp[(v.nexp-1-m)*8 +: 8]));
      check({v.name, " full keystream"}, 128'(data_out), 128'(rc4_model(v.key, v.len)));
   endtask

   task automatic drop_start();
      start = 1'b0;
      step();
      check("back to idle", 128'(state), 128'd0);
   endtask

   logic [8*N-1:0] seq_key;

   initial begin
      for (int m = 0; m < N; m++) seq_key[m*8 +: 8] = 8'(m);
      vecs[0] = '{"Key",    128'h796B4B & 128'h79654B | 128'h79654B, 8'd3, 10, 80'hEB9F7781B734CA72A719};
      vecs[1] = '{"Wiki",   128'h696B6957, 8'd4, 6, 80'h6044DB6D41B7};
      vecs[2] = '{"Secret", 128'h746572636553, 8'd6, 8, 80'h04D46B053CA87B59};
      vecs[3] = '{"len0",   seq_key, 8'd0,  0, 80'h0};
      vecs[4] = '{"len16",  seq_key, 8'd16, 0, 80'h0};
      vecs[5] = '{"len200", seq_key, 8'd200, 0, 80'h0};

      rst_n = 1'b1; start = 1'b0; key = '0; key_length = 8'd0;
      step(); step();
      check("reset state", 128'(state), 128'd0);
      check("reset done", 128'(done), 128'd0);
      check("reset data_out", 128'(data_out), 128'd0);
      check("reset ijk", 128'({i, j, k, temp_addr}), 128'd0);
      rst_n = 1'b0;
      step();
      check("idle without start", 128'(state), 128'd0);

      for (int v = 0; v < 6; v++) begin
         run_vec(vecs[v], 1'b0);
         drop_start();
      end
      check("len0 equals full model", 128'(rc4_model(seq_key, 8'd0)), 128'(data_out));

      // Abort in the middle of key scheduling.
      key = vecs[1].key; key_length = 8'd4; start = 1'b1;
      for (int c = 0; c < 400; c++) step();
      check("mid-KSA flag", 128'(KSA), 128'd1);
      start = 1'b0;
      rst_n = 1'b1;
      step();
      check("abort state", 128'(state), 128'd0);
      check("abort done", 128'(done), 128'd0);
      check("abort data_out", 128'(data_out), 128'd0);
      rst_n = 1'b0;
      run_vec(vecs[0], 1'b0);

      // Holding start keeps DONE; key changes after latch are ignored.
      for (int c = 0; c < 5; c++) begin
         step();
         check("held start stays done", 128'({done, state}), 128'({1'b1, 3'd7}));
      end
      drop_start();
      run_vec(vecs[1], 1'b1);
      drop_start();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
